// File: rtl/apb_soc_ctrl_arb.sv
// Two-port round-robin APB arbiter in front of the SoC control register slave.
// Optional ACCESS-phase timeout is enabled by defining APB_SOC_ARB_TIMEOUT_EN.
module apb_soc_ctrl_arb #(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  // port 0: FC core
  input  logic [APB_ADDR_WIDTH-1:0] s0_PADDR,
  input  logic [31:0]               s0_PWDATA,
  input  logic                      s0_PWRITE,
  input  logic                      s0_PSEL,
  input  logic                      s0_PENABLE,
  output logic [31:0]               s0_PRDATA,
  output logic                      s0_PREADY,
  output logic                      s0_PSLVERR,
  // port 1: debug / JTAG master
  input  logic [APB_ADDR_WIDTH-1:0] s1_PADDR,
  input  logic [31:0]               s1_PWDATA,
  input  logic                      s1_PWRITE,
  input  logic                      s1_PSEL,
  input  logic                      s1_PENABLE,
  output logic [31:0]               s1_PRDATA,
  output logic                      s1_PREADY,
  output logic                      s1_PSLVERR,
  // shared slave side
  output logic [APB_ADDR_WIDTH-1:0] m_PADDR,
  output logic [31:0]               m_PWDATA,
  output logic                      m_PWRITE,
  output logic                      m_PSEL,
  output logic                      m_PENABLE,
  input  logic [31:0]               m_PRDATA,
  input  logic                      m_PREADY,
  input  logic                      m_PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e      state_q;
  logic        gnt_q;
  logic        prio_q;
  logic        timeout;
  logic        complete;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        unused_penable;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Arbitration looks only at PSEL; the requester's PENABLE phase is irrelevant.
  assign unused_penable = s0_PENABLE ^ s1_PENABLE;

`ifdef APB_SOC_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ACCESS && !m_PREADY) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (state_q == ACCESS) && !m_PREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign complete = (state_q == ACCESS) && (m_PREADY || timeout);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      // NOTE: registers take <= so every branch reads the pre-edge values.
      case (state_q)
        IDLE: begin
          if (s0_PSEL || s1_PSEL) begin
            // A tie goes to prio_q; a lone requester wins outright.
            gnt_q   <= (s0_PSEL && s1_PSEL) ? prio_q : s1_PSEL;
            state_q <= SETUP;
          end
        end
        SETUP: state_q <= ACCESS;
        ACCESS: begin
          if (complete) begin
            prio_q  <= ~gnt_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the block leaves an output unassigned (no latch).
    m_PSEL    = 1'b0;
    m_PENABLE = 1'b0;
    m_PADDR   = '0;
    m_PWDATA  = '0;
    m_PWRITE  = 1'b0;
    if (state_q != IDLE) begin
      m_PSEL    = 1'b1;
      m_PENABLE = (state_q == ACCESS);
      if (gnt_q) begin
        m_PADDR  = s1_PADDR;
        m_PWDATA = s1_PWDATA;
        m_PWRITE = s1_PWRITE;
      end else begin
        m_PADDR  = s0_PADDR;
        m_PWDATA = s0_PWDATA;
        m_PWRITE = s0_PWRITE;
      end
    end
  end

  // A timeout answers the stalled requester with a synthetic error response.
  assign resp_rdata = timeout ? 32'hDEAD_BEEF : m_PRDATA;
  assign resp_err   = timeout | m_PSLVERR;

  assign s0_PREADY  = complete && !gnt_q;
  assign s1_PREADY  = complete &&  gnt_q;
  assign s0_PRDATA  = s0_PREADY ? resp_rdata : 32'h0;
  assign s1_PRDATA  = s1_PREADY ? resp_rdata : 32'h0;
  assign s0_PSLVERR = s0_PREADY && resp_err;
  assign s1_PSLVERR = s1_PREADY && resp_err;

endmodule

// File: tb/tb_apb_soc_ctrl_arb.sv
// Randomised + directed bench for apb_soc_ctrl_arb against a transaction-level model.
// Define APB_SOC_ARB_TIMEOUT_EN to also exercise the timeout response.
module tb_apb_soc_ctrl_arb;

`ifdef APB_SOC_ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif
  localparam logic [11:0] ERR_ADDR = 12'h0FC;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] s0_PADDR, s1_PADDR, m_PADDR;
  logic [31:0] s0_PWDATA, s1_PWDATA, s0_PRDATA, s1_PRDATA, m_PWDATA, m_PRDATA;
  logic        s0_PWRITE, s0_PSEL, s0_PENABLE, s0_PREADY, s0_PSLVERR;
  logic        s1_PWRITE, s1_PSEL, s1_PENABLE, s1_PREADY, s1_PSLVERR;
  logic        m_PWRITE, m_PSEL, m_PENABLE, m_PREADY, m_PSLVERR;

  // requester-side drive and observe, indexed by port
  logic [11:0] rq_addr  [2];
  logic [31:0] rq_wdata [2];
  logic        rq_wr    [2];
  logic        rq_psel  [2];
  logic        rq_pen   [2];
  logic        so_rdy   [2];
  logic [31:0] so_rd    [2];
  logic        so_err   [2];

  assign s0_PADDR = rq_addr[0];  assign s1_PADDR = rq_addr[1];
  assign s0_PWDATA = rq_wdata[0]; assign s1_PWDATA = rq_wdata[1];
  assign s0_PWRITE = rq_wr[0];   assign s1_PWRITE = rq_wr[1];
  assign s0_PSEL = rq_psel[0];   assign s1_PSEL = rq_psel[1];
  assign s0_PENABLE = rq_pen[0]; assign s1_PENABLE = rq_pen[1];
  assign so_rdy[0] = s0_PREADY;  assign so_rdy[1] = s1_PREADY;
  assign so_rd[0] = s0_PRDATA;   assign so_rd[1] = s1_PRDATA;
  assign so_err[0] = s0_PSLVERR; assign so_err[1] = s1_PSLVERR;

  apb_soc_ctrl_arb #(
    .APB_ADDR_WIDTH (12),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .s0_PADDR   (s0_PADDR),
    .s0_PWDATA  (s0_PWDATA),
    .s0_PWRITE  (s0_PWRITE),
    .s0_PSEL    (s0_PSEL),
    .s0_PENABLE (s0_PENABLE),
    .s0_PRDATA  (s0_PRDATA),
    .s0_PREADY  (s0_PREADY),
    .s0_PSLVERR (s0_PSLVERR),
    .s1_PADDR   (s1_PADDR),
    .s1_PWDATA  (s1_PWDATA),
    .s1_PWRITE  (s1_PWRITE),
    .s1_PSEL    (s1_PSEL),
    .s1_PENABLE (s1_PENABLE),
    .s1_PRDATA  (s1_PRDATA),
    .s1_PREADY  (s1_PREADY),
    .s1_PSLVERR (s1_PSLVERR),
    .m_PADDR    (m_PADDR),
    .m_PWDATA   (m_PWDATA),
    .m_PWRITE   (m_PWRITE),
    .m_PSEL     (m_PSEL),
    .m_PENABLE  (m_PENABLE),
    .m_PRDATA   (m_PRDATA),
    .m_PREADY   (m_PREADY),
    .m_PSLVERR  (m_PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // environment and reference state
  logic [31:0] sl_mem  [1024];
  logic [31:0] ref_mem [1024];
  xfer_t       q0[$], q1[$];
  xfer_t       cur      [2];
  bit          busy     [2];
  bit          en       [2];
  bit          done     [2];
  int          start_cyc[2];
  int          lat      [2];
  logic [31:0] last_rd  [2];
  logic        last_err [2];
  logic [11:0] mlog[$];
  int          cyc, bus_ph, gnt_m, last_srv, acc_n;
  int          sl_cnt, sl_tgt, sl_fixed, s1_err_cnt;
  bit          rand_mode;

  function automatic xfer_t mk(input logic [11:0] a, input logic [31:0] d, input logic w);
    xfer_t x;
    x.addr  = a;
    x.wdata = d;
    x.wr    = w;
    return x;
  endfunction

  function automatic int q_size(input int p);
    return (p == 0) ? q0.size() : q1.size();
  endfunction

  task automatic push(input int p, input xfer_t x);
    if (p == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  task automatic pop(input int p, output xfer_t x);
    if (p == 0) x = q0.pop_front();
    else        x = q1.pop_front();
  endtask

  function automatic bit all_idle();
    return bus_ph == 0 && !busy[0] && !busy[1] && !done[0] && !done[1] &&
           q0.size() == 0 && q1.size() == 0;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mctl"}, 32'({m_PSEL, m_PENABLE, m_PWRITE}), 32'd0);
    check({tag, "_maddr"}, 32'(m_PADDR), 32'd0);
    check({tag, "_mwdata"}, m_PWDATA, 32'd0);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s_s%0d_ctl", tag, p), 32'({so_rdy[p], so_err[p]}), 32'd0);
      check($sformatf("%s_s%0d_rdata", tag, p), so_rd[p], 32'd0);
    end
  endtask

  task automatic do_reset(input string tag);
    HRESETn = 1'b0;
    #1;
    check_outputs_zero(tag);
    bus_ph = 0; gnt_m = 0; last_srv = 1; acc_n = 0;
    q0.delete(); q1.delete(); mlog.delete();
    for (int p = 0; p < 2; p++) begin
      busy[p] = 0; en[p] = 0; done[p] = 0;
      rq_psel[p] = 0; rq_pen[p] = 0; rq_addr[p] = '0; rq_wdata[p] = '0; rq_wr[p] = 0;
    end
    m_PREADY = 0;
    @(posedge HCLK);
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  // One clock: drive requesters and slave after the edge, check at the falling edge.
  task automatic step();
    xfer_t x;
    @(posedge HCLK);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (done[p]) begin
        busy[p] = 0; en[p] = 0; done[p] = 0;
      end else if (busy[p]) begin
        en[p] = 1;
      end
      if (!busy[p]) begin
        if (rand_mode && q_size(p) == 0 && $urandom_range(0, 2) != 0)
          push(p, mk(($urandom_range(0, 15) == 0) ? ERR_ADDR : 12'($urandom_range(0, 7) * 4),
                     $urandom, 1'($urandom)));
        if (q_size(p) != 0) begin
          pop(p, x);
          cur[p] = x; busy[p] = 1; en[p] = 0; start_cyc[p] = cyc;
        end
      end
      rq_psel[p] = busy[p];
      rq_pen[p]  = en[p];
      if (busy[p]) begin
        rq_addr[p] = cur[p].addr; rq_wdata[p] = cur[p].wdata; rq_wr[p] = cur[p].wr;
      end else begin
        rq_addr[p] = 12'($urandom); rq_wdata[p] = $urandom; rq_wr[p] = 1'($urandom);
      end
    end
    #1;
    m_PREADY = 0; m_PRDATA = $urandom; m_PSLVERR = 1'($urandom);
    if (m_PSEL && !m_PENABLE) begin
      sl_cnt = 0;
      sl_tgt = (sl_fixed >= 0) ? sl_fixed : int'($urandom_range(0, 3));
    end else if (m_PSEL && m_PENABLE) begin
      if (sl_cnt == sl_tgt) begin
        m_PREADY  = 1;
        m_PSLVERR = (m_PADDR == ERR_ADDR);
        m_PRDATA  = (m_PADDR == ERR_ADDR) ? 32'hDEAD_BEEF : sl_mem[m_PADDR[11:2]];
      end else begin
        sl_cnt++;
      end
    end
    @(negedge HCLK);
    sample();
  endtask

  task automatic sample();
    bit          to_hit, bus_done, exp_rdy, is_err;
    logic [31:0] exp_d, exp_a, exp_w;
    logic        exp_wr;
    to_hit = 0;
`ifdef APB_SOC_ARB_TIMEOUT_EN
    to_hit = (bus_ph == 2) && !m_PREADY && (acc_n == TB_TIMEOUT - 1);
`endif
    bus_done = (bus_ph == 2) && (m_PREADY || to_hit);

    check("m_psel", 32'(m_PSEL), 32'(bus_ph != 0));
    check("m_penable", 32'(m_PENABLE), 32'(bus_ph == 2));
    exp_a  = (bus_ph != 0) ? 32'(rq_addr[gnt_m]) : 32'd0;
    exp_w  = (bus_ph != 0) ? rq_wdata[gnt_m] : 32'd0;
    exp_wr = (bus_ph != 0) ? rq_wr[gnt_m] : 1'b0;
    check("m_paddr", 32'(m_PADDR), exp_a);
    check("m_pwdata", m_PWDATA, exp_w);
    check("m_pwrite", 32'(m_PWRITE), 32'(exp_wr));

    for (int p = 0; p < 2; p++) begin
      exp_rdy = bus_done && (gnt_m == p);
      exp_d   = exp_rdy ? (to_hit ? 32'hDEAD_BEEF : m_PRDATA) : 32'd0;
      check($sformatf("s%0d_pready", p), 32'(so_rdy[p]), 32'(exp_rdy));
      check($sformatf("s%0d_prdata", p), so_rd[p], exp_d);
      check($sformatf("s%0d_pslverr", p), 32'(so_err[p]), 32'(exp_rdy && (to_hit || m_PSLVERR)));
      if (exp_rdy) begin
        is_err = (cur[p].addr == ERR_ADDR) || to_hit;
        check($sformatf("s%0d_e2e_err", p), 32'(so_err[p]), 32'(is_err));
        if (!cur[p].wr)
          check($sformatf("s%0d_e2e_rdata", p), so_rd[p],
                is_err ? 32'hDEAD_BEEF : ref_mem[cur[p].addr[11:2]]);
        else if (!is_err)
          ref_mem[cur[p].addr[11:2]] = cur[p].wdata;
        lat[p]      = cyc - start_cyc[p];
        last_rd[p]  = so_rd[p];
        last_err[p] = so_err[p];
        done[p]     = 1;
        check($sformatf("s%0d_wait_bound", p), 32'(lat[p] <= 11), 32'd1);
      end
    end

    if (m_PSEL && m_PENABLE && m_PREADY && m_PWRITE && m_PADDR != ERR_ADDR)
      sl_mem[m_PADDR[11:2]] = m_PWDATA;
    if (m_PSEL && !m_PENABLE) mlog.push_back(m_PADDR);
    s1_err_cnt += int'(s1_PSLVERR);

    // Protocol-level expectation for the next cycle.
    case (bus_ph)
      0: if (rq_psel[0] || rq_psel[1]) begin
           bus_ph = 1;
           if (rq_psel[0] && rq_psel[1]) gnt_m = (last_srv == 0) ? 1 : 0;
           else                          gnt_m = rq_psel[1] ? 1 : 0;
         end
      1: begin bus_ph = 2; acc_n = 0; end
      default: if (bus_done) begin bus_ph = 0; last_srv = gnt_m; end
               else acc_n++;
    endcase
  endtask

  task automatic run_idle(input int max_cyc, input string tag);
    int i = 0;
    do begin
      step();
      i++;
    end while (i < max_cyc && !all_idle());
    check({tag, "_done_in_time"}, 32'(all_idle()), 32'd1);
  endtask

  initial begin
    HRESETn = 1'b0;
    cyc = 0; sl_cnt = 0; sl_tgt = 0; sl_fixed = -1; rand_mode = 0; s1_err_cnt = 0;
    m_PRDATA = '0; m_PSLVERR = 0; m_PREADY = 0;
    for (int i = 0; i < 1024; i++) begin
      sl_mem[i]  = $urandom;
      ref_mem[i] = sl_mem[i];
    end
    sl_mem[0]  = 32'h0004_0000;
    ref_mem[0] = 32'h0004_0000;

    do_reset("reset");

    // single read with two slave wait states
    sl_fixed = 2;
    push(0, mk(12'h000, 32'h0, 1'b0));
    run_idle(40, "t1");
    check("t1_latency", 32'(lat[0]), 32'd4);
    check("t1_rdata", last_rd[0], 32'h0004_0000);

    // simultaneous writes right after reset: port 0 first
    do_reset("t2_rst");
    sl_fixed = -1;
    push(0, mk(12'h004, 32'h1C00_0080, 1'b1));
    push(1, mk(12'h400, 32'h0000_0301, 1'b1));
    run_idle(60, "t2");
    check("t2_count", 32'(mlog.size()), 32'd2);
    if (mlog.size() == 2) begin
      check("t2_first", 32'(mlog[0]), 32'h004);
      check("t2_second", 32'(mlog[1]), 32'h400);
    end
    check("t2_mem0", sl_mem[1], 32'h1C00_0080);
    check("t2_mem1", sl_mem[256], 32'h0000_0301);

    // round-robin: four back-to-back reads per port
    do_reset("t3_rst");
    for (int i = 0; i < 4; i++) begin
      push(0, mk(12'(i * 4), 32'h0, 1'b0));
      push(1, mk(12'h400 + 12'(i * 4), 32'h0, 1'b0));
    end
    run_idle(200, "t3");
    check("t3_count", 32'(mlog.size()), 32'd8);
    for (int i = 0; i < mlog.size(); i++)
      check($sformatf("t3_order%0d", i), 32'(mlog[i][10]), 32'(i % 2));

    // error pass-through on port 1
    s1_err_cnt = 0;
    push(1, mk(ERR_ADDR, 32'h0, 1'b0));
    run_idle(40, "t4");
    check("t4_err", 32'(last_err[1]), 32'd1);
    check("t4_rdata", last_rd[1], 32'hDEAD_BEEF);
    check("t4_err_cycles", 32'(s1_err_cnt), 32'd1);

    // reset while port 0 sits in ACCESS with the slave stalled
    sl_fixed = 50;
    push(0, mk(12'h010, 32'h0, 1'b0));
    for (int i = 0; i < 20 && bus_ph != 2; i++) step();
    step();
    step();
    check("t5_in_access", 32'(m_PENABLE), 32'd1);
    #2;
    do_reset("t5_rst");
    sl_fixed = -1;
    push(0, mk(12'h008, 32'h0, 1'b0));
    push(1, mk(12'h408, 32'h0, 1'b0));
    run_idle(60, "t5");
    if (mlog.size() > 0) check("t5_first_tie", 32'(mlog[0]), 32'h008);
    else                 check("t5_first_tie", 32'hFFFF_FFFF, 32'h008);

`ifdef APB_SOC_ARB_TIMEOUT_EN
    // slave never ready: timeout answers on the 4th ACCESS cycle
    do_reset("t6_rst");
    sl_fixed = 100;
    push(0, mk(12'h010, 32'h0, 1'b0));
    run_idle(40, "t6");
    check("t6_latency", 32'(lat[0]), 32'(TB_TIMEOUT + 1));
    check("t6_err", 32'(last_err[0]), 32'd1);
    check("t6_rdata", last_rd[0], 32'hDEAD_BEEF);
    sl_fixed = -1;
`endif

    // randomised traffic from both ports
    do_reset("rand_rst");
    rand_mode = 1;
    repeat (2000) step();
    rand_mode = 0;
    run_idle(100, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
